chscan_arbiter: RTL and testbench

Round-robin scan controller for the 4-channel virtual-input capture path. It shares the 4:1 channel mux between four requesters by driving the mux select and a one-hot grant, which is the decoder-equivalent. It holds each grant for a fixed dwell and captures the selected channel bit into a registered sample for the ChipScope probe. It replaces the free-running select counter with request-driven, fair sequencing.

---
 rtl/chscan_pkg.sv | 21 ++
 rtl/chscan_rr_pick.sv | 32 +++
 rtl/chscan_arbiter.sv | 160 ++++++++++++++++
 tb/tb_chscan_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chscan_pkg.sv
// chscan_pkg: shared types and constants for the round-robin channel scan arbiter.
package chscan_pkg;

    localparam int N_CH  = 4;
    localparam int CH_W  = 2;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // One-hot decode of a channel index into a grant vector.
    function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] ch);
        logic [N_CH-1:0] one;
        one = {{(N_CH-1){1'b0}}, 1'b1};
        return one << ch;
    endfunction

endpackage

// File: rtl/chscan_rr_pick.sv
// chscan_rr_pick: combinational rotate-priority pick. The search starts at
// i_last+1 and wraps, so the most recently served channel has lowest priority.
module chscan_rr_pick
    import chscan_pkg::*;
(
    input  logic [N_CH-1:0] i_req,
    input  logic [CH_W-1:0] i_last,
    output logic [CH_W-1:0] o_winner,
    output logic            o_any
);

    logic [CH_W-1:0] w_idx;
    logic [CH_W-1:0] w_win;

    // Walk from lowest to highest priority so the highest-priority requester overwrites.
    always_comb begin
        w_idx = {CH_W{1'b0}};
        w_win = {CH_W{1'b0}};
        for (int k = N_CH; k >= 1; k--) begin
            w_idx = i_last + CH_W'(k);
            if (i_req[w_idx]) begin
                w_win = w_idx;
            end else begin
                w_win = w_win;
            end
        end
    end

    assign o_winner = w_win;
    assign o_any    = |i_req;

endmodule

// File: rtl/chscan_arbiter.sv
// chscan_arbiter: request-driven round-robin scan controller for the 4:1
// capture mux. Each grant is held for DWELL cycles, then the selected channel
// bit is captured into a registered sample with a one-cycle valid pulse.
// Optional feature macro: CHSCAN_GRANT_CNT_EN adds o_grant_cnt, four 8-bit
// saturating per-channel completion counters.
module chscan_arbiter
    import chscan_pkg::*;
#(
    parameter int unsigned DWELL = 8
)
(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_CH-1:0]        i_req,
    input  logic [N_CH-1:0]        i_ch_data,
    output logic [CH_W-1:0]        o_sel,
    output logic [N_CH-1:0]        o_grant,
    output logic                   o_busy,
    output logic                   o_sample_valid,
    output logic                   o_sample_data,
    output logic [CH_W-1:0]        o_sample_ch
`ifdef CHSCAN_GRANT_CNT_EN
    ,
    output logic [N_CH*CNT_W-1:0]  o_grant_cnt
`endif
);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

    state_t            r_state;
    logic [CH_W-1:0]   r_sel;
    logic [N_CH-1:0]   r_grant;
    logic [CH_W-1:0]   r_last;
    logic [CNT_W-1:0]  r_dwell_cnt;
    logic              r_busy;
    logic              r_sample_valid;
    logic              r_sample_data;
    logic [CH_W-1:0]   r_sample_ch;

    state_t            w_state_nxt;
    logic [CH_W-1:0]   w_sel_nxt;
    logic [N_CH-1:0]   w_grant_nxt;
    logic [CH_W-1:0]   w_last_nxt;
    logic [CNT_W-1:0]  w_dwell_cnt_nxt;
    logic              w_sample_valid_nxt;
    logic              w_sample_data_nxt;
    logic [CH_W-1:0]   w_sample_ch_nxt;
    logic              w_complete;

    logic [CH_W-1:0]   w_winner;
    logic              w_any;

    chscan_rr_pick u_pick (
        .i_req    (i_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Next-state and next-output decode; abort is checked before completion.
    always_comb begin
        w_state_nxt        = r_state;
        w_sel_nxt          = r_sel;
        w_grant_nxt        = r_grant;
        w_last_nxt         = r_last;
        w_dwell_cnt_nxt    = r_dwell_cnt;
        w_sample_valid_nxt = 1'b0;
        w_sample_data_nxt  = r_sample_data;
        w_sample_ch_nxt    = r_sample_ch;
        w_complete         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_sel_nxt       = w_winner;
                    w_grant_nxt     = onehot(w_winner);
                    w_dwell_cnt_nxt = {CNT_W{1'b0}};
                    w_state_nxt     = ST_GRANT;
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!i_req[r_sel]) begin
                    w_grant_nxt = {N_CH{1'b0}};
                    w_last_nxt  = r_sel;
                    w_state_nxt = ST_RELEASE;
                end else if (r_dwell_cnt == DWELL_LAST) begin
                    w_complete         = 1'b1;
                    w_sample_data_nxt  = i_ch_data[r_sel];
                    w_sample_ch_nxt    = r_sel;
                    w_sample_valid_nxt = 1'b1;
                    w_grant_nxt        = {N_CH{1'b0}};
                    w_last_nxt         = r_sel;
                    w_state_nxt        = ST_RELEASE;
                end else begin
                    w_dwell_cnt_nxt    = r_dwell_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_grant_nxt = {N_CH{1'b0}};
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers; last pointer resets to 3 so ch0 wins first.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= ST_IDLE;
            r_sel          <= {CH_W{1'b0}};
            r_grant        <= {N_CH{1'b0}};
            r_last         <= {CH_W{1'b1}};
            r_dwell_cnt    <= {CNT_W{1'b0}};
            r_busy         <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= 1'b0;
            r_sample_ch    <= {CH_W{1'b0}};
        end else begin
            r_state        <= w_state_nxt;
            r_sel          <= w_sel_nxt;
            r_grant        <= w_grant_nxt;
            r_last         <= w_last_nxt;
            r_dwell_cnt    <= w_dwell_cnt_nxt;
            r_busy         <= (w_state_nxt != ST_IDLE);
            r_sample_valid <= w_sample_valid_nxt;
            r_sample_data  <= w_sample_data_nxt;
            r_sample_ch    <= w_sample_ch_nxt;
        end
    end

    assign o_sel          = r_sel;
    assign o_grant        = r_grant;
    assign o_busy         = r_busy;
    assign o_sample_valid = r_sample_valid;
    assign o_sample_data  = r_sample_data;
    assign o_sample_ch    = r_sample_ch;

`ifdef CHSCAN_GRANT_CNT_EN
    logic [CNT_W-1:0] r_grant_cnt [N_CH];

    // Per-channel completion counters, saturating at all-ones; aborts never count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < N_CH; i++) begin
                r_grant_cnt[i] <= {CNT_W{1'b0}};
            end
        end else if (w_complete && (r_grant_cnt[r_sel] != {CNT_W{1'b1}})) begin
            r_grant_cnt[r_sel] <= r_grant_cnt[r_sel] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign o_grant_cnt[g*CNT_W +: CNT_W] = r_grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_chscan_arbiter.sv
// tb_chscan_arbiter: directed scenarios with a scoreboard. Stimulus pushes the
// expected grant windows and samples (with their cycle stamps) into queues; a
// monitor pops and compares whenever a grant rises/falls or a sample is valid.
module tb_chscan_arbiter;

    localparam int DW = 4;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] sel;
        int         start;
        int         stop;
    } gexp_t;

    typedef struct {
        logic       data;
        logic [1:0] ch;
        int         at;
    } sexp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [3:0] ch_data;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       busy;
    logic       sample_valid;
    logic       sample_data;
    logic [1:0] sample_ch;
`ifdef CHSCAN_GRANT_CNT_EN
    logic [31:0] grant_cnt;
`endif

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    gexp_t gq[$];
    sexp_t sq[$];
    gexp_t act;
    logic [3:0] prev_grant = 4'b0000;

    chscan_arbiter #(.DWELL(DW)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req          (req),
        .i_ch_data      (ch_data),
        .o_sel          (sel),
        .o_grant        (grant),
        .o_busy         (busy),
        .o_sample_valid (sample_valid),
        .o_sample_data  (sample_data),
        .o_sample_ch    (sample_ch)
`ifdef CHSCAN_GRANT_CNT_EN
        ,
        .o_grant_cnt    (grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, actual, required);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic push_g(input logic [3:0] g, input logic [1:0] s, input int start, input int stop);
        gexp_t e;
        e.grant = g; e.sel = s; e.start = start; e.stop = stop;
        gq.push_back(e);
    endtask

    task automatic push_s(input logic d, input logic [1:0] ch, input int at);
        sexp_t e;
        e.data = d; e.ch = ch; e.at = at;
        sq.push_back(e);
    endtask

    task automatic monitor();
        sexp_t s;
        forever begin
            @(negedge clk);
            if (grant !== prev_grant) begin
                if (prev_grant !== 4'b0000) begin
                    chk("grant_stop_cycle", 32'(cyc), 32'(act.stop));
                end
                if (grant !== 4'b0000) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_grant", {28'b0, grant}, 32'h0);
                    end else begin
                        act = gq.pop_front();
                        chk("grant_value", {28'b0, grant}, {28'b0, act.grant});
                        chk("grant_sel", {30'b0, sel}, {30'b0, act.sel});
                        chk("grant_start_cycle", 32'(cyc), 32'(act.start));
                    end
                end
            end
            if (sample_valid === 1'b1) begin
                if (sq.size() == 0) begin
                    chk("unexpected_sample", {31'b0, sample_valid}, 32'h0);
                end else begin
                    s = sq.pop_front();
                    chk("sample_data", {31'b0, sample_data}, {31'b0, s.data});
                    chk("sample_ch", {30'b0, sample_ch}, {30'b0, s.ch});
                    chk("sample_cycle", 32'(cyc), 32'(s.at));
                end
            end
            prev_grant = grant;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, {28'b0, grant}, 32'h0);
        chk({tag, "_sel"}, {30'b0, sel}, 32'h0);
        chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
        chk({tag, "_sample_valid"}, {31'b0, sample_valid}, 32'h0);
        chk({tag, "_sample_data"}, {31'b0, sample_data}, 32'h0);
        chk({tag, "_sample_ch"}, {30'b0, sample_ch}, 32'h0);
    endtask

    initial begin
        int t;
        logic [3:0] dat;
        logic [1:0] ch;
        rst = 1'b1;
        req = 4'b0000;
        ch_data = 4'b0000;
        fork
            monitor();
        join_none

        // Reset values, then a single ch0 request.
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0; req = 4'b0001; ch_data = 4'b0001;
        t = cyc;
        push_g(4'b0001, 2'd0, t + 1, t + 5);
        push_s(1'b1, 2'd0, t + 5);
        tick_until(t + 2);
        chk("busy_in_grant", {31'b0, busy}, 32'h1);
        tick_until(t + 5);
        chk("busy_in_release", {31'b0, busy}, 32'h1);
        req = 4'b0000;
        tick_until(t + 7);
        chk("busy_idle", {31'b0, busy}, 32'h0);

        // Wrap priority: ch1 completes, then 1010 picks ch3 before ch1.
        ch_data = 4'b0110; req = 4'b0010;
        t = cyc;
        push_g(4'b0010, 2'd1, t + 1, t + 5);
        push_s(1'b1, 2'd1, t + 5);
        push_g(4'b1000, 2'd3, t + 7, t + 11);
        push_s(1'b0, 2'd3, t + 11);
        push_g(4'b0010, 2'd1, t + 13, t + 17);
        push_s(1'b1, 2'd1, t + 17);
        tick_until(t + 5);
        req = 4'b1010;
        tick_until(t + 17);
        req = 4'b0000;
        tick_until(t + 19);

        // Abort: ch2 drops its request in its second grant cycle; ch3 follows.
        ch_data = 4'b1000; req = 4'b1100;
        t = cyc;
        push_g(4'b0100, 2'd2, t + 1, t + 3);
        push_g(4'b1000, 2'd3, t + 5, t + 9);
        push_s(1'b1, 2'd3, t + 9);
        tick_until(t + 2);
        req = 4'b1000;
        tick_until(t + 9);
        req = 4'b0000;
        tick_until(t + 11);

        // Reset during the third grant cycle of ch1.
        ch_data = 4'b0101; req = 4'b0010;
        t = cyc;
        push_g(4'b0010, 2'd1, t + 1, t + 4);
        tick_until(t + 3);
        rst = 1'b1;
        tick_until(t + 4);
        chk_all_zero("mid_reset");

        // Fairness after reset: all requesting, ch0 first, period DW+2.
        rst = 1'b0; req = 4'b1111;
        t = cyc;
        for (int k = 0; k < 5; k++) begin
            ch = 2'(k % 4);
            dat = ch_data;
            push_g(4'b0001 << ch, ch, t + 1 + 6 * k, t + 5 + 6 * k);
            push_s(dat[ch], ch, t + 5 + 6 * k);
        end
        tick_until(t + 29);
        req = 4'b0000;
        ch_data = 4'b0000;
        tick_until(t + 34);
        chk("sample_data_hold", {31'b0, sample_data}, 32'h1);
        chk("sample_ch_hold", {30'b0, sample_ch}, 32'h0);

`ifdef CHSCAN_GRANT_CNT_EN
        // Saturation: 300 completed dwells on ch0.
        rst = 1'b1;
        tick();
        chk("grant_cnt_reset", grant_cnt, 32'h0);
        rst = 1'b0; req = 4'b0001; ch_data = 4'b0001;
        t = cyc;
        for (int k = 0; k < 300; k++) begin
            push_g(4'b0001, 2'd0, t + 1 + 6 * k, t + 5 + 6 * k);
            push_s(1'b1, 2'd0, t + 5 + 6 * k);
        end
        tick_until(t + 5 + 6 * 299);
        req = 4'b0000;
        tick_until(t + 3 + 6 * 300);
        chk("grant_cnt_saturated", grant_cnt, 32'h0000_00FF);
`endif

        tick(); tick();
        chk("grant_queue_drained", 32'(gq.size()), 32'h0);
        chk("sample_queue_drained", 32'(sq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
